pdm_capture_ctrl: RTL and testbench

Controller that sequences the CIC3 PDM decimator inside the TinyQV PDM microphone peripheral.
- Generates the microphone PDM clock and a per-bit sample strobe.
- Holds the decimator in reset during microphone warm-up, then discards the first PCM samples while the filter settles.
- Buffers valid PCM words in a small FIFO that the host drains through the peripheral register interface.
- Raises overflow and interrupt status.
All logic runs on the system clock; the decimator is clock-enabled by pdm_sample_en.

---
 rtl/pdm_pkg.sv | 21 ++
 rtl/pdm_sample_fifo.sv | 63 ++++++
 rtl/pdm_capture_ctrl.sv | 140 ++++++++++++++
 tb/tb_pdm_capture_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared types and default constants for the PDM microphone capture path.
package pdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } pdm_state_e;

  localparam int unsigned WARMUP_CYCLES_DEF = 1024;
  localparam int unsigned DISCARD_DEF       = 4;
  localparam int unsigned FIFO_DEPTH_DEF    = 4;
  localparam int unsigned PCM_W             = 16;

  // Bits needed to count 0..v-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/pdm_sample_fifo.sv
// Synchronous first-word-fall-through FIFO for PCM words; a push into a full
// FIFO is rejected unless a pop frees a slot in the same cycle.
module pdm_sample_fifo
  import pdm_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned W     = PCM_W,
  parameter int unsigned LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     rd_data,
  output logic [LVL_W-1:0] level,
  output logic             empty,
  output logic             full_c,
  output logic             drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_n;
  logic [LVL_W-1:0] level_n;
  logic             do_push;
  logic             do_pop;

  assign full_c   = (level == LVL_W'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full_c | do_pop);
  assign drop_c   = push & ~do_push;
  assign rd_ptr_n = rd_ptr + AW'(do_pop);
  assign level_n  = level + LVL_W'(do_push) - LVL_W'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // rd_data is registered with the post-update head so it is valid the cycle
  // after a push into an empty FIFO and holds its value once drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      empty   <= 1'b1;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_n;
      level  <= level_n;
      empty  <= (level_n == '0);
      if (level_n != '0) begin
        rd_data <= (do_push && (rd_ptr_n == wr_ptr)) ? push_data : mem[rd_ptr_n];
      end
    end
  end

endmodule

// File: rtl/pdm_capture_ctrl.sv
// Sequences the CIC3 PDM decimator: PDM clock generation, microphone warm-up,
// filter settling discard, PCM buffering and status/interrupt generation.
module pdm_capture_ctrl
  import pdm_pkg::*;
#(
  parameter int unsigned DIV_W         = 8,
  parameter int unsigned WARMUP_CYCLES = WARMUP_CYCLES_DEF,
  parameter int unsigned DISCARD       = DISCARD_DEF,
  parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter int unsigned LVL_W         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  output logic             pdm_clk,
  output logic             pdm_sample_en,
  output logic             cic_rst,
  input  logic [PCM_W-1:0] pcm_in,
  input  logic             pcm_valid_in,
  input  logic             rd_en,
  output logic [PCM_W-1:0] rd_data,
  output logic [LVL_W-1:0] fifo_level,
  output logic             fifo_empty,
  output logic             overflow,
  input  logic             ovf_clear,
  input  logic [LVL_W-1:0] irq_thresh,
  output logic             irq,
  output logic [1:0]       state
);

  localparam int unsigned WARM_W    = clog2_min1(WARMUP_CYCLES);
  localparam int unsigned DISC_W    = clog2_min1(DISCARD);
  localparam int unsigned WARM_LAST = WARMUP_CYCLES - 1;
  localparam int unsigned DISC_LAST = (DISCARD == 0) ? 0 : DISCARD - 1;

  pdm_state_e       st;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;
  logic [WARM_W-1:0] warm_cnt;
  logic [DISC_W-1:0] disc_cnt;
  logic             tc_c;
  logic             push_c;
  logic             fifo_full_c;
  logic             fifo_drop_c;

  assign tc_c   = (div_cnt == div_q);
  assign push_c = (st == ST_RUN) & pcm_valid_in;

  // Divider and sequencing FSM; the divider only runs outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st            <= ST_IDLE;
      div_q         <= '0;
      div_cnt       <= '0;
      pdm_clk       <= 1'b0;
      pdm_sample_en <= 1'b0;
      cic_rst       <= 1'b1;
      warm_cnt      <= '0;
      disc_cnt      <= '0;
    end else if (!enable) begin
      st            <= ST_IDLE;
      div_cnt       <= '0;
      pdm_clk       <= 1'b0;
      pdm_sample_en <= 1'b0;
      cic_rst       <= 1'b1;
      warm_cnt      <= '0;
      disc_cnt      <= '0;
    end else begin
      pdm_sample_en <= 1'b0;
      if (st == ST_IDLE) begin
        st      <= ST_WARMUP;
        div_q   <= clk_div;
        div_cnt <= '0;
      end else begin
        if (tc_c) begin
          div_cnt       <= '0;
          pdm_clk       <= ~pdm_clk;
          pdm_sample_en <= ~pdm_clk;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end

        case (st)
          ST_WARMUP: begin
            if (pdm_sample_en) begin
              if (warm_cnt == WARM_W'(WARM_LAST)) begin
                st      <= ST_SETTLE;
                cic_rst <= 1'b0;
              end else begin
                warm_cnt <= warm_cnt + WARM_W'(1);
              end
            end
          end
          // Leave on the edge of the last discarded strobe so a word arriving
          // the very next cycle is already captured.
          ST_SETTLE: begin
            if (DISCARD == 0) begin
              st <= ST_RUN;
            end else if (pcm_valid_in) begin
              if (disc_cnt == DISC_W'(DISC_LAST)) st <= ST_RUN;
              else disc_cnt <= disc_cnt + DISC_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  pdm_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PCM_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (pcm_in),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .full_c    (fifo_full_c),
    .drop_c    (fifo_drop_c)
  );

  // A drop wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              overflow <= 1'b0;
    else if (fifo_drop_c) overflow <= 1'b1;
    else if (ovf_clear)   overflow <= 1'b0;
  end

  drop_implies_full: assert property (@(posedge clk) disable iff (rst) fifo_drop_c |-> fifo_full_c);

  assign irq   = overflow | ((irq_thresh != '0) & (fifo_level >= irq_thresh));
  assign state = st;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Randomised self-checking bench for pdm_capture_ctrl with a queue-based reference model.
module tb_pdm_capture_ctrl;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned WARM  = 16;
  localparam int unsigned DISC  = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVL_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [DIV_W-1:0] clk_div;
  logic             pdm_clk;
  logic             pdm_sample_en;
  logic             cic_rst;
  logic [15:0]      pcm_in;
  logic             pcm_valid_in;
  logic             rd_en;
  logic [15:0]      rd_data;
  logic [LVL_W-1:0] fifo_level;
  logic             fifo_empty;
  logic             overflow;
  logic             ovf_clear;
  logic [LVL_W-1:0] irq_thresh;
  logic             irq;
  logic [1:0]       state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_q[$];
  logic [15:0] m_last;
  logic        m_ovf;

  always #5 clk = ~clk;

  pdm_capture_ctrl #(
    .DIV_W(DIV_W), .WARMUP_CYCLES(WARM), .DISCARD(DISC),
    .FIFO_DEPTH(DEPTH), .LVL_W(LVL_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clk_div(clk_div),
    .pdm_clk(pdm_clk), .pdm_sample_en(pdm_sample_en), .cic_rst(cic_rst),
    .pcm_in(pcm_in), .pcm_valid_in(pcm_valid_in), .rd_en(rd_en),
    .rd_data(rd_data), .fifo_level(fifo_level), .fifo_empty(fifo_empty),
    .overflow(overflow), .ovf_clear(ovf_clear), .irq_thresh(irq_thresh),
    .irq(irq), .state(state)
  );

  task automatic test_reset();
    logic [26:0] obs;
    logic [26:0] exp;
    rst = 1'b1; enable = 1'b0; clk_div = '0; pcm_in = '0; pcm_valid_in = 1'b0;
    rd_en = 1'b0; ovf_clear = 1'b0; irq_thresh = '0;
    exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 16'h0000};
    repeat (3) @(negedge clk);
    for (int c = 0; c < 21; c++) begin
      if (c == 1) rst = 1'b0;
      if (c > 0) @(negedge clk);
      obs = {pdm_clk, pdm_sample_en, cic_rst, fifo_empty, overflow, irq, state, fifo_level, rd_data};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset c=%0d: got %h want %h", c, obs, exp);
      end
    end
    m_q.delete(); m_last = '0; m_ovf = 1'b0;
  endtask

  // Enable from IDLE with divider d and check the PDM clock, strobe, warm-up
  // length and state cycle by cycle until a few cycles into SETTLE.
  task automatic test_divider(input int d);
    int          kw;
    int          chg;
    int          pulses;
    logic        e_clk;
    logic        e_se;
    logic        e_warm;
    logic [4:0]  obs;
    logic [4:0]  exp;
    int          lvl0;
    kw     = (2 * WARM - 1) * (d + 1);
    chg    = $urandom_range(1, kw);
    pulses = 0;
    lvl0   = m_q.size();
    clk_div = DIV_W'(d);
    enable  = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= kw + 3; k++) begin
      if (k > 0) @(negedge clk);
      e_clk  = ((k / (d + 1)) % 2) == 1;
      e_se   = (k % (2 * (d + 1))) == (d + 1);
      e_warm = (k <= kw);
      exp = {e_clk, e_se, e_warm, (e_warm ? 2'd1 : 2'd2)};
      obs = {pdm_clk, pdm_sample_en, cic_rst, state};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL divider d=%0d k=%0d: got clk,se,cic_rst,state=%b want %b", d, k, obs, exp);
      end
      if (pdm_sample_en === 1'b1 && state === 2'd1) pulses++;
      if (k == chg) clk_div = DIV_W'($urandom_range(0, 255));
      pcm_in       = 16'($urandom);
      pcm_valid_in = (k < kw) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    pcm_valid_in = 1'b0;
    n_tests++;
    if (pulses != WARM || int'(fifo_level) != lvl0) begin
      n_fail++;
      $display("FAIL warmup_pulses: got pulses=%0d level=%0d want pulses=%0d level=%0d",
               pulses, fifo_level, WARM, lvl0);
    end
  endtask

  task automatic test_settle();
    logic [15:0] words [3];
    int          gap;
    logic [1:0]  e_st;
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    for (int j = 0; j < 3; j++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        e_st = (j >= int'(DISC)) ? 2'd3 : 2'd2;
        n_tests++;
        if (state !== e_st) begin
          n_fail++;
          $display("FAIL settle_gap j=%0d: got state=%0d want %0d", j, state, e_st);
        end
      end
      pcm_in = words[j]; pcm_valid_in = 1'b1;
      @(negedge clk);
      pcm_valid_in = 1'b0;
      if (j >= int'(DISC)) m_q.push_back(words[j]);
      e_st = (j + 1 >= int'(DISC)) ? 2'd3 : 2'd2;
      n_tests++;
      if (state !== e_st) begin
        n_fail++;
        $display("FAIL settle_state j=%0d: got state=%0d want %0d", j, state, e_st);
      end
    end
    if (m_q.size() > 0) m_last = m_q[0];
    n_tests++;
    if (int'(fifo_level) != m_q.size() || rd_data !== m_last || m_q[m_q.size()-1] !== 16'h3333) begin
      n_fail++;
      $display("FAIL settle_fifo: got level=%0d head=%h want level=%0d head=%h",
               fifo_level, rd_data, m_q.size(), m_last);
    end
  endtask

  // One clock of FIFO traffic, checked against the queue model.
  task automatic run_fifo_cycle(input bit push, input logic [15:0] data, input bit pop,
                                input bit clr, input logic [LVL_W-1:0] th);
    bit          popped;
    bit          pushed;
    logic        e_irq;
    logic [21:0] obs;
    logic [21:0] exp;
    pcm_in = data; pcm_valid_in = push; rd_en = pop; ovf_clear = clr; irq_thresh = th;
    @(negedge clk);
    pcm_valid_in = 1'b0; rd_en = 1'b0; ovf_clear = 1'b0;
    popped = pop && (m_q.size() > 0);
    if (popped) void'(m_q.pop_front());
    pushed = push && (m_q.size() < int'(DEPTH));
    if (pushed) m_q.push_back(data);
    if (push && !pushed) m_ovf = 1'b1;
    else if (clr)        m_ovf = 1'b0;
    if (m_q.size() > 0) m_last = m_q[0];
    e_irq = m_ovf || (th != '0 && m_q.size() >= int'(th));
    exp = {LVL_W'(m_q.size()), (m_q.size() == 0), m_ovf, e_irq, m_last};
    obs = {fifo_level, fifo_empty, overflow, irq, rd_data};
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL fifo push=%0d pop=%0d clr=%0d th=%0d: got lvl,empty,ovf,irq,data=%h want %h",
               push, pop, clr, th, obs, exp);
    end
  endtask

  task automatic test_overflow();
    while (m_q.size() > 0) run_fifo_cycle(1'b0, 16'h0, 1'b1, 1'b0, '0);
    for (int i = 1; i <= 5; i++) run_fifo_cycle(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0, '0);
    n_tests++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: got level=%0d ovf=%b irq=%b want 4 1 1", fifo_level, overflow, irq);
    end
    for (int i = 1; i <= 4; i++) begin
      n_tests++;
      if (rd_data !== 16'hA000 + 16'(i)) begin
        n_fail++;
        $display("FAIL overflow_pop%0d: got %h want %h", i, rd_data, 16'hA000 + 16'(i));
      end
      run_fifo_cycle(1'b0, 16'h0, 1'b1, 1'b0, '0);
    end
    run_fifo_cycle(1'b0, 16'h0, 1'b0, 1'b1, '0);
    n_tests++;
    if (overflow !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: got ovf=%b irq=%b want 0 0", overflow, irq);
    end
  endtask

  task automatic test_back_to_back();
    while (m_q.size() < int'(DEPTH)) run_fifo_cycle(1'b1, 16'($urandom), 1'b0, 1'b0, '0);
    run_fifo_cycle(1'b1, 16'hB000, 1'b1, 1'b0, '0);
    n_tests++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_push_pop: got level=%0d ovf=%b want 4 0", fifo_level, overflow);
    end
    repeat (3) run_fifo_cycle(1'b0, 16'h0, 1'b1, 1'b0, '0);
    n_tests++;
    if (rd_data !== 16'hB000 || fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL full_tail: got data=%h level=%0d want b000 1", rd_data, fifo_level);
    end
    run_fifo_cycle(1'b0, 16'h0, 1'b1, 1'b0, '0);
    n_tests++;
    if (fifo_empty !== 1'b1 || rd_data !== 16'hB000) begin
      n_fail++;
      $display("FAIL empty_hold: got empty=%b data=%h want 1 b000", fifo_empty, rd_data);
    end
    run_fifo_cycle(1'b1, 16'hC0DE, 1'b1, 1'b0, '0);
    n_tests++;
    if (fifo_level !== 3'd1 || rd_data !== 16'hC0DE) begin
      n_fail++;
      $display("FAIL empty_push_pop: got level=%0d data=%h want 1 c0de", fifo_level, rd_data);
    end
    while (m_q.size() < int'(DEPTH)) run_fifo_cycle(1'b1, 16'($urandom), 1'b0, 1'b0, '0);
    run_fifo_cycle(1'b1, 16'hDEAD, 1'b0, 1'b1, '0);
    n_tests++;
    if (overflow !== 1'b1 || fifo_level !== 3'd4) begin
      n_fail++;
      $display("FAIL drop_with_clear: got ovf=%b level=%0d want 1 4", overflow, fifo_level);
    end
    run_fifo_cycle(1'b0, 16'h0, 1'b0, 1'b1, '0);
  endtask

  task automatic test_random(input int cycles);
    logic [LVL_W-1:0] th;
    th = '0;
    for (int c = 0; c < cycles; c++) begin
      if (c % 25 == 0) th = LVL_W'($urandom_range(0, 4));
      run_fifo_cycle(1'($urandom_range(0, 1)), 16'($urandom), ($urandom % 3) == 0,
                     ($urandom % 16) == 0, th);
    end
    irq_thresh = '0;
  endtask

  task automatic test_disable();
    logic [3:0] obs;
    while (m_q.size() > 0) run_fifo_cycle(1'b0, 16'h0, 1'b1, 1'b0, '0);
    run_fifo_cycle(1'b0, 16'h0, 1'b0, 1'b1, '0);
    run_fifo_cycle(1'b1, 16'($urandom), 1'b0, 1'b0, '0);
    run_fifo_cycle(1'b1, 16'($urandom), 1'b0, 1'b0, '0);
    enable = 1'b0; irq_thresh = 3'd2;
    @(negedge clk);
    obs = {state, pdm_clk, cic_rst};
    n_tests++;
    if (obs !== 4'b0001 || pdm_sample_en !== 1'b0 || fifo_level !== 3'd2 ||
        rd_data !== m_q[0] || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL disable: got state,clk,cic_rst=%b se=%b level=%0d data=%h irq=%b want 0001 0 2 %h 1",
               obs, pdm_sample_en, fifo_level, rd_data, irq, m_q[0]);
    end
    repeat (3) run_fifo_cycle(1'b0, 16'h0, 1'b0, 1'b0, 3'd2);
    pcm_in = 16'h5A5A; pcm_valid_in = 1'b1;
    @(negedge clk);
    pcm_valid_in = 1'b0;
    n_tests++;
    if (fifo_level !== 3'd2 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_ignore: got level=%0d state=%0d want 2 0", fifo_level, state);
    end
    run_fifo_cycle(1'b0, 16'h0, 1'b1, 1'b0, 3'd2);
    n_tests++;
    if (irq !== 1'b0 || fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL disable_irq_pop: got irq=%b level=%0d want 0 1", irq, fifo_level);
    end
    irq_thresh = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_divider(3);
    test_settle();
    test_overflow();
    test_back_to_back();
    test_random(250);
    test_disable();
    test_divider($urandom_range(0, 4));
    test_settle();
    test_random(60);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
